// File: rtl/traffic_sensor_ctrl.sv
// Request generator for the two-road light FSM: conditions raw detectors, tracks queues
// and green time, and drives TA/TB/E. Define EMERG_LATCH_EN to latch E until the avenue has served MIN_GREEN.
module traffic_sensor_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int MIN_GREEN     = 8,
    parameter int MAX_GREEN     = 32,
    parameter int DEPART_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_a_in,
    input  logic             car_b_in,
    input  logic             emerg_in,
    input  logic [1:0]       verde,
    output logic             TA,
    output logic             TB,
    output logic             E,
    output logic [CNT_W-1:0] queue_a,
    output logic [CNT_W-1:0] queue_b
);

    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int DEP_W = (DEPART_CYCLES > 2) ? $clog2(DEPART_CYCLES) : 1;
    localparam int GC_W  = $clog2(MAX_GREEN + 1);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEP_W-1:0] DEP_LAST  = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [GC_W-1:0]  GC_MIN    = GC_W'(MIN_GREEN);
    localparam logic [GC_W-1:0]  GC_MAX    = GC_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] QUEUE_MAX = {CNT_W{1'b1}};

    // channel order: [0] avenue car, [1] boulevard car, [2] emergency
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       filt;
    logic [1:0]       filt_d;
    logic [DEB_W-1:0] deb_cnt [3];

    logic [GC_W-1:0]  green_cnt;
    logic [DEP_W-1:0] dep_cnt;
    logic             e_q;

    logic             arrival_a;
    logic             arrival_b;
    logic             dep_active;
    logic             depart;
    logic             depart_a;
    logic             depart_b;
    logic             hold_a;
    logic             hold_b;

    assign raw = {emerg_in, car_b_in, car_a_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_d <= filt[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    filt[i]    <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign arrival_a = filt[0] & ~filt_d[0];
    assign arrival_b = filt[1] & ~filt_d[1];

    // One departure timer serves whichever road is green; it restarts whenever service stops.
    assign dep_active = ((verde == 2'b01) && (queue_a != '0)) ||
                        ((verde == 2'b10) && (queue_b != '0));
    assign depart     = dep_active && (dep_cnt == DEP_LAST);
    assign depart_a   = depart && (verde == 2'b01);
    assign depart_b   = depart && (verde == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dep_cnt <= '0;
        end else if (!dep_active || depart) begin
            dep_cnt <= '0;
        end else begin
            dep_cnt <= dep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue_a <= '0;
        end else if (arrival_a && !depart_a && (queue_a != QUEUE_MAX)) begin
            queue_a <= queue_a + 1'b1;
        end else if (depart_a && !arrival_a && (queue_a != '0)) begin
            queue_a <= queue_a - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue_b <= '0;
        end else if (arrival_b && !depart_b && (queue_b != QUEUE_MAX)) begin
            queue_b <= queue_b + 1'b1;
        end else if (depart_b && !arrival_b && (queue_b != '0)) begin
            queue_b <= queue_b - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            green_cnt <= '0;
        end else if (verde == 2'b00) begin
            green_cnt <= '0;
        end else if (green_cnt != GC_MAX) begin
            green_cnt <= green_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= 1'b0;
        end else begin
`ifdef EMERG_LATCH_EN
            if (filt[2]) begin
                e_q <= 1'b1;
            end else if (verde[0] && (green_cnt >= GC_MIN)) begin
                e_q <= 1'b0;
            end
`else
            e_q <= filt[2];
`endif
        end
    end

    assign hold_a = (green_cnt < GC_MIN) || (queue_b == '0) ||
                    ((queue_a != '0) && (green_cnt < GC_MAX));
    assign hold_b = (green_cnt < GC_MIN) || (queue_a == '0) ||
                    ((queue_b != '0) && (green_cnt < GC_MAX));

    // Gated by reset so the FSM never sees a hold request while this block is cleared.
    assign TA = !reset && (verde == 2'b01) && hold_a;
    assign TB = !reset && (verde == 2'b10) && hold_b;
    assign E  = e_q;

endmodule

// File: tb/tb_traffic_sensor_ctrl.sv
// Bench for traffic_sensor_ctrl: pulse table, directed corner sequences, and a randomized
// run compared every cycle against a sample-history reference model.
module tb_traffic_sensor_ctrl;

    localparam int DEB  = 4;
    localparam int MIN  = 8;
    localparam int MAX  = 32;
    localparam int DEP  = 4;
    localparam int QMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_a_in = 1'b0;
    logic       car_b_in = 1'b0;
    logic       emerg_in = 1'b0;
    logic [1:0] verde = 2'b00;
    logic       TA, TB, E;
    logic [3:0] queue_a, queue_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    traffic_sensor_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .car_a_in (car_a_in),
        .car_b_in (car_b_in),
        .emerg_in (emerg_in),
        .verde    (verde),
        .TA       (TA),
        .TB       (TB),
        .E        (E),
        .queue_a  (queue_a),
        .queue_b  (queue_b)
    );

    always #5 clk = ~clk;

    // Reference: raw-sample history per channel; a filtered value flips when the last DEB
    // synchronized samples (raw delayed two edges) all disagree with it.
    logic [7:0] mh [3];
    logic       mf [3];
    logic       mfd [3];
    int         mqa, mqb, mgc, mrun;
    logic       me;

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            mh[c]  = '0;
            mf[c]  = 1'b0;
            mfd[c] = 1'b0;
        end
        mqa = 0; mqb = 0; mgc = 0; mrun = 0; me = 1'b0;
    endtask

    function automatic int clampq(int v);
        if (v < 0) return 0;
        if (v > QMAX) return QMAX;
        return v;
    endfunction

    task automatic model_edge();
        logic r [3];
        logic nf [3];
        logic arr [3];
        logic act, dep, all_opp;
        int   da, db;
        if (reset) begin
            model_clear();
            return;
        end
        r[0] = car_a_in; r[1] = car_b_in; r[2] = emerg_in;
        for (int c = 0; c < 3; c++) begin
            all_opp = 1'b1;
            for (int i = 1; i <= DEB; i++) begin
                if (mh[c][i] == mf[c]) all_opp = 1'b0;
            end
            nf[c]  = all_opp ? ~mf[c] : mf[c];
            arr[c] = mf[c] & ~mfd[c];
        end
        act = ((verde == 2'b01) && (mqa != 0)) || ((verde == 2'b10) && (mqb != 0));
        dep = act && ((mrun % DEP) == DEP - 1);
        da  = (arr[0] ? 1 : 0) - ((dep && verde == 2'b01) ? 1 : 0);
        db  = (arr[1] ? 1 : 0) - ((dep && verde == 2'b10) ? 1 : 0);
`ifdef EMERG_LATCH_EN
        if (mf[2]) me = 1'b1;
        else if (verde[0] && mgc >= MIN) me = 1'b0;
`else
        me = mf[2];
`endif
        mqa  = clampq(mqa + da);
        mqb  = clampq(mqb + db);
        mrun = act ? mrun + 1 : 0;
        mgc  = (verde == 2'b00) ? 0 : ((mgc < MAX) ? mgc + 1 : MAX);
        for (int c = 0; c < 3; c++) begin
            mfd[c] = mf[c];
            mf[c]  = nf[c];
            mh[c]  = {mh[c][6:0], r[c]};
        end
    endtask

    function automatic logic model_ta();
        return !reset && (verde == 2'b01) &&
               (mgc < MIN || mqb == 0 || (mqa != 0 && mgc < MAX));
    endfunction

    function automatic logic model_tb();
        return !reset && (verde == 2'b10) &&
               (mgc < MIN || mqa == 0 || (mqb != 0 && mgc < MAX));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock edge, model advanced with the same inputs, then compared 1ns after the edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("model_queue_a", int'(queue_a), mqa);
            chk("model_queue_b", int'(queue_b), mqb);
            chk("model_TA", int'(TA), int'(model_ta()));
            chk("model_TB", int'(TB), int'(model_tb()));
            chk("model_E", int'(E), int'(me));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        car_a_in = 1'b0; car_b_in = 1'b0; emerg_in = 1'b0; verde = 2'b00;
        run(2);
        reset = 1'b0;
        run(2);
    endtask

    task automatic pulse_a(input int hi, input int lo);
        car_a_in = 1'b1; run(hi);
        car_a_in = 1'b0; run(lo);
    endtask

    task automatic pulse_b(input int hi, input int lo);
        car_b_in = 1'b1; run(hi);
        car_b_in = 1'b0; run(lo);
    endtask

    typedef struct {
        int a_len;
        int b_len;
        int exp_qa;
        int exp_qb;
    } pulse_vec_t;

    pulse_vec_t vecs [7];

    initial begin
        int ha, hb, he, hv, rst_hold;
        model_clear();

        vecs[0] = '{2, 0, 0, 0};
        vecs[1] = '{3, 4, 0, 1};
        vecs[2] = '{4, 0, 1, 1};
        vecs[3] = '{10, 3, 2, 1};
        vecs[4] = '{0, 10, 2, 2};
        vecs[5] = '{5, 5, 3, 3};
        vecs[6] = '{1, 1, 3, 3};

        // reset held with inputs toggling and a green light present
        reset = 1'b1;
        verde = 2'b01;
        for (int k = 0; k < 10; k++) begin
            car_a_in = k[0]; car_b_in = ~k[0]; emerg_in = k[1];
            run(1);
            chk("rst_TA", int'(TA), 0);
            chk("rst_TB", int'(TB), 0);
            chk("rst_E", int'(E), 0);
            chk("rst_qa", int'(queue_a), 0);
            chk("rst_qb", int'(queue_b), 0);
        end
        car_a_in = 1'b0; car_b_in = 1'b0; emerg_in = 1'b0; verde = 2'b00;
        reset = 1'b0;
        run(5);
        chk("post_rst_TA", int'(TA), 0);
        chk("post_rst_qa", int'(queue_a), 0);
        chk("post_rst_E", int'(E), 0);

        // pulse-length table, no green so no departures
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 10; k++) begin
                car_a_in = (k < vecs[v].a_len);
                car_b_in = (k < vecs[v].b_len);
                run(1);
            end
            car_a_in = 1'b0; car_b_in = 1'b0;
            run(12);
            chk("tbl_queue_a", int'(queue_a), vecs[v].exp_qa);
            chk("tbl_queue_b", int'(queue_b), vecs[v].exp_qb);
            chk("tbl_TA_idle", int'(TA), 0);
        end

        // arrival latency: raw high first sampled at edge 1, queue moves at edge 7
        do_reset();
        car_a_in = 1'b1;
        run(6);
        chk("latency_edge6", int'(queue_a), 0);
        run(1);
        chk("latency_edge7", int'(queue_a), 1);
        run(3);
        car_a_in = 1'b0;
        run(10);
        chk("latency_single", int'(queue_a), 1);

        // saturation at 15 after 16 arrivals
        do_reset();
        for (int k = 0; k < 16; k++) pulse_a(6, 8);
        chk("sat_queue_a", int'(queue_a), 15);
        pulse_b(6, 8);
        pulse_b(6, 8);
        chk("sat_queue_b", int'(queue_b), 2);

        // long avenue queue against waiting boulevard: held until green_cnt=32
        verde = 2'b01;
        run(3);
        chk("dep_before", int'(queue_a), 15);
        run(1);
        chk("dep_first", int'(queue_a), 14);
        run(27);
        chk("max_TA_31", int'(TA), 1);
        run(1);
        chk("max_TA_32", int'(TA), 0);
        chk("max_qa_32", int'(queue_a), 7);
        chk("max_TB", int'(TB), 0);
        verde = 2'b00;
        run(2);

        // empty cross road holds avenue indefinitely; waiting cross road releases at 8
        do_reset();
        verde = 2'b01;
        run(50);
        chk("hold_TA_qb0", int'(TA), 1);
        verde = 2'b00;
        run(2);
        for (int k = 0; k < 3; k++) pulse_b(6, 8);
        chk("min_qb", int'(queue_b), 3);
        verde = 2'b01;
        run(7);
        chk("min_TA_7", int'(TA), 1);
        run(1);
        chk("min_TA_8", int'(TA), 0);
        verde = 2'b11;
        run(1);
        chk("illegal_TA", int'(TA), 0);
        chk("illegal_TB", int'(TB), 0);
        verde = 2'b10;
        run(1);
        chk("bvd_TB", int'(TB), 1);
        verde = 2'b00;
        run(2);

        // emergency: 6-cycle pulse
        do_reset();
        emerg_in = 1'b1;
        run(6);
        chk("emerg_edge6", int'(E), 0);
        emerg_in = 1'b0;
        run(1);
        chk("emerg_edge7", int'(E), 1);
        run(5);
        chk("emerg_edge12", int'(E), 1);
        run(1);
`ifdef EMERG_LATCH_EN
        chk("emerg_latched", int'(E), 1);
        verde = 2'b01;
        run(8);
        chk("emerg_held_gc8", int'(E), 1);
        run(1);
        chk("emerg_cleared", int'(E), 0);
        verde = 2'b00;
`else
        chk("emerg_follow", int'(E), 0);
`endif
        run(3);

        // randomized traffic with occasional mid-run reset
        do_reset();
        ha = 0; hb = 0; he = 0; hv = 0; rst_hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (ha == 0) begin car_a_in = $urandom_range(0, 1); ha = $urandom_range(1, 12); end
            if (hb == 0) begin car_b_in = $urandom_range(0, 1); hb = $urandom_range(1, 12); end
            if (he == 0) begin emerg_in = ($urandom_range(0, 9) == 0); he = $urandom_range(1, 15); end
            if (hv == 0) begin
                case ($urandom_range(0, 19))
                    0:              verde = 2'b11;
                    1, 2, 3, 4, 5:  verde = 2'b00;
                    6, 7, 8, 9, 10, 11, 12: verde = 2'b01;
                    default:        verde = 2'b10;
                endcase
                hv = $urandom_range(3, 50);
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b0;
            end else if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                rst_hold = 2;
            end
            ha--; hb--; he--; hv--;
            run(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
